// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues req/ack fetches to
// instruction memory and queues {pc, inst} pairs for decode over valid/ready.
module ifetch_queue #(
   parameter int unsigned        AWIDTH   = 32,
   parameter int unsigned        IWIDTH   = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [AWIDTH-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [AWIDTH-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [IWIDTH-1:0] mem_rdata,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_pc,
   output logic              inst_valid,
   output logic [IWIDTH-1:0] inst,
   output logic [AWIDTH-1:0] inst_pc,
   input  logic              inst_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   localparam logic [0:0] S_FETCH   = 1'b0;
   localparam logic [0:0] S_DISCARD = 1'b1;

   logic [0:0]        r_state;
   logic [AWIDTH-1:0] r_fetch_pc;
   logic [AWIDTH-1:0] r_pend_pc;
   logic [PW:0]       r_count;
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [AWIDTH-1:0] r_pc_mem   [DEPTH];
   logic [IWIDTH-1:0] r_inst_mem [DEPTH];

   logic              w_req;
   logic              w_ack;
   logic              w_valid;
   logic              w_push;
   logic              w_pop;
   logic [AWIDTH-1:0] w_redir_pc;

   // A DISCARD request is always held; in FETCH a request only issues with room
   assign w_req      = !rst && ((r_state == S_DISCARD) || (r_count != FULL));
   assign w_ack      = w_req && mem_ack;
   assign w_valid    = !rst && (r_count != '0);
   assign w_push     = (r_state == S_FETCH) && w_ack && !redirect;
   assign w_pop      = w_valid && inst_ready && !redirect;
   assign w_redir_pc = redirect_pc & ~AWIDTH'(3);

   assign mem_req    = w_req;
   assign mem_addr   = r_fetch_pc;
   assign inst_valid = w_valid;
   assign inst       = w_valid ? r_inst_mem[r_rd_ptr] : '0;
   assign inst_pc    = w_valid ? r_pc_mem[r_rd_ptr]   : '0;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
         r_inst_mem[r_wr_ptr] <= mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_fetch_pc <= RESET_PC;
         r_pend_pc  <= RESET_PC;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         if (redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end

         case (r_state)
            S_FETCH: begin
               // An unacked request cannot be withdrawn, so its data must be drained first
               if (redirect && w_req && !mem_ack) begin
                  r_pend_pc <= w_redir_pc;
                  r_state   <= S_DISCARD;
               end else if (redirect) begin
                  r_fetch_pc <= w_redir_pc;
               end else if (w_ack) begin
                  r_fetch_pc <= r_fetch_pc + AWIDTH'(4);
               end
            end
            default: begin
               if (redirect) r_pend_pc <= w_redir_pc;
               if (mem_ack) begin
                  r_fetch_pc <= redirect ? w_redir_pc : r_pend_pc;
                  r_state    <= S_FETCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus random traffic checked
// against a queue-based reference model of the fetch front end.
module tb_ifetch_queue;

   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] PAT    = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_ack = 1'b0;
   logic        redirect = 1'b0;
   logic        inst_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req;
   logic        inst_valid;
   logic [31:0] mem_addr;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_qpc [$];
   logic [31:0] m_qin [$];
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_pend = '0;
   bit          m_disc = 1'b0;

   ifetch_queue #(
      .AWIDTH(32),
      .IWIDTH(32),
      .DEPTH(DEPTH),
      .RESET_PC(RST_PC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .inst_valid(inst_valid),
      .inst(inst),
      .inst_pc(inst_pc),
      .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   function automatic bit m_req();
      return !rst && (m_disc || (m_qpc.size() < DEPTH));
   endfunction

   // One clock edge; the reference model consumes the same inputs the DUT samples.
   task automatic tick();
      bit req;
      bit valid;
      req   = m_req();
      valid = !rst && (m_qpc.size() != 0);
      @(posedge clk);
      if (rst) begin
         m_qpc.delete(); m_qin.delete();
         m_pc = RST_PC; m_disc = 1'b0;
      end else if (m_disc) begin
         if (redirect) m_pend = redirect_pc & ~32'h3;
         if (mem_ack) begin m_pc = m_pend; m_disc = 1'b0; end
      end else if (redirect) begin
         m_qpc.delete(); m_qin.delete();
         if (req && !mem_ack) begin m_pend = redirect_pc & ~32'h3; m_disc = 1'b1; end
         else m_pc = redirect_pc & ~32'h3;
      end else begin
         if (valid && inst_ready) begin void'(m_qpc.pop_front()); void'(m_qin.pop_front()); end
         if (req && mem_ack) begin
            m_qpc.push_back(m_pc); m_qin.push_back(mem_rdata);
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0F00;
      tick();
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
      n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", inst); end
      n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
      n_cmp++; if (mem_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr: got %h want %h", mem_addr, RST_PC); end
      redirect = 1'b0;
      do_reset();
   endtask

   task automatic test_streaming();
      do_reset();
      mem_ack = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         n_cmp++; if (mem_addr !== 32'(4*k)) begin n_err++; $display("FAIL stream_addr: got %h want %h", mem_addr, 32'(4*k)); end
         n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stream_req: got %b want 1", mem_req); end
         n_cmp++; if (inst_valid !== (k != 0)) begin n_err++; $display("FAIL stream_valid: got %b want %b", inst_valid, k != 0); end
         if (k > 0) begin
            n_cmp++; if (inst_pc !== 32'(4*(k-1))) begin n_err++; $display("FAIL stream_pc: got %h want %h", inst_pc, 32'(4*(k-1))); end
            n_cmp++; if (inst !== (32'(4*(k-1)) ^ PAT)) begin n_err++; $display("FAIL stream_inst: got %h want %h", inst, 32'(4*(k-1)) ^ PAT); end
         end
         mem_rdata = mem_addr ^ PAT;
         tick();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      mem_ack = 1'b1; inst_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'(4*k)) begin n_err++; $display("FAIL bp_fill: got %b/%h want 1/%h", mem_req, mem_addr, 32'(4*k)); end
         mem_rdata = mem_addr ^ PAT;
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h10) begin n_err++; $display("FAIL bp_full: got %b/%h want 0/00000010", mem_req, mem_addr); end
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL bp_head: got %b/%h want 1/00000000", inst_valid, inst_pc); end
         tick();
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_err++; $display("FAIL bp_reissue: got %b/%h want 1/00000010", mem_req, mem_addr); end
      n_cmp++; if (inst_pc !== 32'h4) begin n_err++; $display("FAIL bp_pop: got %h want 00000004", inst_pc); end
      mem_rdata = 32'h10 ^ PAT;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h14) begin n_err++; $display("FAIL bp_refull: got %b/%h want 0/00000014", mem_req, mem_addr); end
      inst_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4+4*j)) begin n_err++; $display("FAIL bp_drain_pc: got %b/%h want 1/%h", inst_valid, inst_pc, 32'(4+4*j)); end
         n_cmp++; if (inst !== (32'(4+4*j) ^ PAT)) begin n_err++; $display("FAIL bp_drain_inst: got %h want %h", inst, 32'(4+4*j) ^ PAT); end
         tick();
      end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", inst_valid); end
   endtask

   task automatic test_idle_redirect();
      do_reset();
      mem_ack = 1'b1; inst_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin mem_rdata = mem_addr ^ PAT; tick(); end
      mem_ack = 1'b0;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", mem_req); end
      redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL idle_flush: got %b want 0", inst_valid); end
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_err++; $display("FAIL idle_addr: got %b/%h want 1/00000100", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_0100;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'hCAFE_0100) begin n_err++; $display("FAIL idle_first: got %b/%h/%h want 1/00000100/cafe0100", inst_valid, inst_pc, inst); end
   endtask

   task automatic test_redirect_pending();
      do_reset();
      mem_ack = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin mem_rdata = mem_addr ^ PAT; tick(); end
      mem_ack = 1'b0;
      tick();
      redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_err++; $display("FAIL pend_hold1: got %b/%h want 1/00000008", mem_req, mem_addr); end
      redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_err++; $display("FAIL pend_hold2: got %b/%h want 1/00000008", mem_req, mem_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL pend_flush: got %b want 0", inst_valid); end
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_0008;
      tick();
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || inst_valid !== 1'b0) begin n_err++; $display("FAIL pend_restart: got %b/%h/%b want 1/00000300/0", mem_req, mem_addr, inst_valid); end
      mem_rdata = 32'h0300_AAAA;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300 || inst !== 32'h0300_AAAA) begin n_err++; $display("FAIL pend_first: got %b/%h/%h want 1/00000300/0300aaaa", inst_valid, inst_pc, inst); end
   endtask

   task automatic test_redirect_ack();
      do_reset();
      mem_ack = 1'b1; inst_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin mem_rdata = mem_addr ^ PAT; tick(); end
      redirect = 1'b1; redirect_pc = 32'h40; mem_rdata = 32'h0808_0808;
      tick();
      redirect = 1'b0;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rack_flush: got %b want 0", inst_valid); end
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_err++; $display("FAIL rack_addr: got %b/%h want 1/00000040", mem_req, mem_addr); end
      mem_rdata = 32'h4040_4040;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== 32'h4040_4040) begin n_err++; $display("FAIL rack_first: got %b/%h/%h want 1/00000040/40404040", inst_valid, inst_pc, inst); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_ack = 1'b1; inst_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin mem_rdata = mem_addr ^ PAT; tick(); end
      mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h500;
      tick();
      redirect = 1'b0;
      n_cmp++; if (mem_addr !== 32'h8 || mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_disc: got %b/%h want 1/00000008", mem_req, mem_addr); end
      rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_gate: got %b/%b want 0/0", mem_req, inst_valid); end
      n_cmp++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_err++; $display("FAIL rmid_zero: got %h/%h want 0/0", inst, inst_pc); end
      tick();
      n_cmp++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || mem_addr !== RST_PC) begin n_err++; $display("FAIL rmid_held: got %b/%b/%h want 0/0/%h", mem_req, inst_valid, mem_addr, RST_PC); end
      rst = 1'b0; mem_ack = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== RST_PC || inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_release: got %b/%h/%b want 1/%h/0", mem_req, mem_addr, inst_valid, RST_PC); end
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ack = 1'b0;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== 32'h1234_5678) begin n_err++; $display("FAIL rmid_first: got %b/%h/%h want 1/%h/12345678", inst_valid, inst_pc, inst, RST_PC); end
   endtask

   task automatic test_random();
      bit          prev_pend;
      logic [31:0] prev_addr;
      logic [31:0] exp_pc;
      logic [31:0] exp_in;
      bit          exp_v;
      do_reset();
      prev_pend = 1'b0; prev_addr = '0;
      for (int c = 0; c < 1500; c++) begin
         rst         = ($urandom_range(99) == 0);
         mem_ack     = ($urandom_range(2) != 0);
         inst_ready  = ($urandom_range(3) != 0);
         redirect    = ($urandom_range(11) == 0);
         redirect_pc = $urandom;
         mem_rdata   = $urandom;
         #1;
         exp_v  = !rst && (m_qpc.size() != 0);
         exp_pc = exp_v ? m_qpc[0] : 32'h0;
         exp_in = exp_v ? m_qin[0] : 32'h0;
         n_cmp++; if (mem_req !== m_req()) begin n_err++; $display("FAIL rnd_req c=%0d: got %b want %b", c, mem_req, m_req()); end
         n_cmp++; if (mem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, mem_addr, m_pc); end
         n_cmp++; if (inst_valid !== exp_v) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, inst_valid, exp_v); end
         n_cmp++; if (inst_pc !== exp_pc || inst !== exp_in) begin n_err++; $display("FAIL rnd_head c=%0d: got %h/%h want %h/%h", c, inst_pc, inst, exp_pc, exp_in); end
         if (prev_pend && !rst) begin
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin n_err++; $display("FAIL rnd_stable c=%0d: got %b/%h want 1/%h", c, mem_req, mem_addr, prev_addr); end
         end
         prev_pend = mem_req && !mem_ack;
         prev_addr = mem_addr;
         tick();
      end
      rst = 1'b0; redirect = 1'b0; mem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_idle_redirect();
      test_redirect_pending();
      test_redirect_ack();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
